// File: rtl/writeback_arbiter.sv
// Write-side master for the 32x32 register bank. It merges single-cycle ALU
// results with long-latency results, which arrive through a small FIFO. It
// also keeps a pending-destination scoreboard so that decode can stall on
// RAW hazards.
module writeback_arbiter #(
    parameter int DEPTH    = 2,   // long-latency FIFO entries, power of 2, >= 2
    parameter int MAX_WAIT = 4    // cycles the FIFO head may be bypassed, >= 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // single-cycle ALU result path
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_addr,
    input  logic [31:0] i_alu_data,
    output logic        o_alu_stall,
    // long-latency result path (valid/ready)
    input  logic        i_lu_valid,
    output logic        o_lu_ready,
    input  logic [4:0]  i_lu_addr,
    input  logic [31:0] i_lu_data,
    // long-latency issue and decode hazard query
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_addr,
    input  logic [4:0]  i_addr_Rs,
    input  logic [4:0]  i_addr_Rt,
    output logic        o_busy_Rs,
    output logic        o_busy_Rt,
    // register-bank write port
    output logic        o_con_RegWr,
    output logic [4:0]  o_addr_Rd,
    output logic [31:0] o_data_Rd
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    // FIFO storage and control
    logic [4:0]        fifo_addr [DEPTH];
    logic [31:0]       fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       pending;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pending_next;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);

    // Ready depends on state only, so a pop in the same cycle cannot raise it.
    assign o_lu_ready  = !fifo_full;
    assign o_alu_stall = (wait_cnt == WAIT_MAX);
    assign o_busy_Rs   = pending[i_addr_Rs];
    assign o_busy_Rt   = pending[i_addr_Rt];

    // A transfer to r0 completes the handshake but nothing is stored.
    assign push = i_lu_valid && o_lu_ready && (i_lu_addr != 5'd0);

    // Choose at most one write per cycle. A starved FIFO head beats the ALU.
    always_comb begin
        // NOTE: every output of this block gets a default first; otherwise a
        // path that leaves one unassigned would infer a latch.
        pop     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        if (o_alu_stall && !fifo_empty) begin
            pop = 1'b1;
        end else if (i_alu_valid && (i_alu_addr != 5'd0)) begin
            wr_en   = 1'b1;
            wr_addr = i_alu_addr;
            wr_data = i_alu_data;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end
        if (pop) begin
            wr_en   = 1'b1;
            wr_addr = fifo_addr[rd_ptr];
            wr_data = fifo_data[rd_ptr];
        end
    end

    // Next scoreboard value: a pop clears, an issue sets (set wins), r0 is never busy.
    always_comb begin
        pending_next = pending;
        if (pop) begin
            pending_next[fifo_addr[rd_ptr]] = 1'b0;
        end
        if (i_issue_valid) begin
            pending_next[i_issue_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // FIFO payload storage.
    // NOTE: the payload array has no reset; an empty count makes its contents
    // irrelevant, and leaving it unreset allows plain RAM/flop inference.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_lu_addr;
            fifo_data[wr_ptr] <= i_lu_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the edge.
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: counts the cycles a waiting head is bypassed, saturating at MAX_WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt <= '0;
        end else if (fifo_empty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Pending-destination scoreboard register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Registered register-bank write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_con_RegWr <= 1'b0;
            o_addr_Rd   <= 5'd0;
            o_data_Rd   <= 32'd0;
        end else begin
            o_con_RegWr <= wr_en;
            o_addr_Rd   <= wr_addr;
            o_data_Rd   <= wr_data;
        end
    end

endmodule
